// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
//  Module   : div_iter
//  Purpose  : Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
//             Performs one shift and one trial subtract per cycle over WIDTH
//             cycles, with valid/ready handshakes on both sides and flush.
//  Option   : define DIV_SPECIAL_FASTPATH_EN to finish divide-by-zero and
//             signed overflow in one edge (IDLE->DONE) instead of WIDTH+1.
//  Revision : 1.0  initial release
// ============================================================================
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic             in_rem,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [CW-1:0]      cnt_q,      cnt_d;
    logic [WIDTH-1:0]   rem_q,      rem_d;      // partial remainder
    logic [WIDTH-1:0]   quo_q,      quo_d;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   dvsr_q,     dvsr_d;     // |divisor|
    logic               rem_sel_q,  rem_sel_d;
    logic               q_neg_q,    q_neg_d;
    logic               r_neg_q,    r_neg_d;
    logic               spec_q,     spec_d;
    logic [WIDTH-1:0]   spec_res_q, spec_res_d;
    logic [WIDTH-1:0]   result_q,   result_d;

    // Operand conditioning at acceptance: magnitudes, signs and special cases
    logic               w_a_neg, w_b_neg, w_div_zero, w_ovf, w_special;
    logic [WIDTH-1:0]   w_a_abs, w_b_abs, w_spec_res;
    // One restoring step: the shifted remainder needs WIDTH+1 bits, and the
    // WIDTH+1-bit difference's MSB is the borrow (shifted < 2*divisor always).
    logic [WIDTH:0]     w_shift, w_sub;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_next, w_quo_next, w_q_fix, w_r_fix;

    // Operand magnitudes, special-case detection and one datapath iteration
    always_comb begin
        w_a_neg    = in_signed & in_dividend[WIDTH-1];
        w_b_neg    = in_signed & in_divisor[WIDTH-1];
        // abs(most-negative) wraps to itself, which read unsigned is 2^(WIDTH-1)
        w_a_abs    = w_a_neg ? -in_dividend : in_dividend;
        w_b_abs    = w_b_neg ? -in_divisor  : in_divisor;
        w_div_zero = (in_divisor == '0);
        w_ovf      = in_signed && (in_dividend == {1'b1, {(WIDTH-1){1'b0}}})
                               && (in_divisor  == '1);
        w_special  = w_div_zero | w_ovf;
        if (w_div_zero)
            w_spec_res = in_rem ? in_dividend : '1;
        else
            w_spec_res = in_rem ? '0 : in_dividend;

        w_shift    = {rem_q, quo_q[WIDTH-1]};
        w_sub      = w_shift - {1'b0, dvsr_q};
        w_ge       = ~w_sub[WIDTH];
        w_rem_next = w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
        w_quo_next = {quo_q[WIDTH-2:0], w_ge};
        w_q_fix    = q_neg_q ? -w_quo_next : w_quo_next;
        w_r_fix    = r_neg_q ? -w_rem_next : w_rem_next;
    end

    // Next-state, datapath updates and handshake outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvsr_d     = dvsr_q;
        rem_sel_d  = rem_sel_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        result_d   = result_q;
        in_ready   = (state_q == S_IDLE) && !flush;
        out_valid  = (state_q == S_DONE);
        out_result = result_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    rem_sel_d  = in_rem;
                    q_neg_d    = (w_a_neg ^ w_b_neg) & ~w_div_zero;
                    r_neg_d    = w_a_neg;
                    spec_d     = w_special;
                    spec_res_d = w_spec_res;
                    rem_d      = '0;
                    quo_d      = w_a_abs;
                    dvsr_d     = w_b_abs;
                    cnt_d      = '0;
`ifdef DIV_SPECIAL_FASTPATH_EN
                    if (w_special) begin
                        state_d  = S_DONE;
                        result_d = w_spec_res;
                    end else begin
                        state_d  = S_BUSY;
                    end
`else
                    state_d    = S_BUSY;
`endif
                end
            end
            S_BUSY: begin
                rem_d = w_rem_next;
                quo_d = w_quo_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    if (spec_q)
                        result_d = spec_res_q;
                    else
                        result_d = rem_sel_q ? w_r_fix : w_q_fix;
                end
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush outranks every other event; any pending result is dropped
        if (flush) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = '0;
        end
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvsr_q     <= '0;
            rem_sel_q  <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvsr_q     <= dvsr_d;
            rem_sel_q  <= rem_sel_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            result_q   <= result_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_iter
//  Purpose  : Scoreboard bench for div_iter: directed vectors with hand-computed
//             results and latencies, handshake hold, flush and mid-op reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div_iter;

    localparam int WIDTH    = 32;
    localparam int FULL_LAT = WIDTH + 1;
`ifdef DIV_SPECIAL_FASTPATH_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = WIDTH + 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic             in_rem;
    logic [WIDTH-1:0] in_dividend;
    logic [WIDTH-1:0] in_divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;

    div_iter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_signed   (in_signed),
        .in_rem      (in_rem),
        .in_dividend (in_dividend),
        .in_divisor  (in_divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               lat;
        int               t0;
        string            name;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: compare every cycle the DUT presents a result against queue head
    initial begin : monitor
        bit seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        chk({sb[0].name, "_latency"}, WIDTH'(cyc - sb[0].t0), WIDTH'(sb[0].lat));
                    end
                    chk(sb[0].name, out_result, sb[0].res);
                    chk({sb[0].name, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
                    if (out_ready && !flush) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    // Present one request at posedge+1; caller is aligned to posedge+1
    task automatic issue(input logic s, input logic r, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp,
                         input int lat, input bit push, input string name);
        int t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) chk({name, "_wait_in_ready"}, 32'd0, 32'd1);
        in_valid    = 1'b1;
        in_signed   = s;
        in_rem      = r;
        in_dividend = a;
        in_divisor  = b;
        if (push) sb.push_back('{exp, lat, cyc, name});
        @(posedge clk); #1;
        in_valid    = 1'b0;
        // Later input changes must be ignored by the in-flight op
        in_signed   = ~s;
        in_rem      = ~r;
        in_dividend = 32'hDEAD_BEEF;
        in_divisor  = 32'h0000_0001;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_signed = 1'b0; in_rem = 1'b0; in_dividend = '0; in_divisor = '0;
        #2;
        chk("reset_out_valid",  {31'd0, out_valid}, 32'd0);
        chk("reset_out_result", out_result, 32'd0);
        cycles(3);
        rst_n = 1'b1;
        cycles(1);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Regular divides
        issue(0, 0, 32'd100,       32'd7,         32'd14,        FULL_LAT, 1, "divu_100_7");  wait_drain();
        issue(0, 1, 32'd100,       32'd7,         32'd2,         FULL_LAT, 1, "remu_100_7");  wait_drain();
        issue(1, 0, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  FULL_LAT, 1, "div_m7_2");    wait_drain();
        issue(1, 1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  FULL_LAT, 1, "rem_m7_2");    wait_drain();
        issue(1, 1, 32'd7,         32'hFFFFFFFE,  32'd1,         FULL_LAT, 1, "rem_7_m2");    wait_drain();
        issue(1, 0, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  FULL_LAT, 1, "div_7_m2");    wait_drain();
        issue(1, 0, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        FULL_LAT, 1, "div_m100_m7"); wait_drain();
        issue(1, 1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'hFFFFFFFE,  FULL_LAT, 1, "rem_m100_m7"); wait_drain();
        issue(0, 0, 32'h80000000,  32'd3,         32'h2AAAAAAA,  FULL_LAT, 1, "divu_big_3");  wait_drain();
        issue(0, 1, 32'h80000000,  32'd3,         32'd2,         FULL_LAT, 1, "remu_big_3");  wait_drain();
        issue(0, 0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  FULL_LAT, 1, "divu_max_1");  wait_drain();
        issue(0, 0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         FULL_LAT, 1, "divu_min_max"); wait_drain();
        issue(0, 1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  FULL_LAT, 1, "remu_min_max"); wait_drain();
        issue(1, 0, 32'h80000000,  32'd1,         32'h80000000,  FULL_LAT, 1, "div_min_1");   wait_drain();

        // Special results
        issue(0, 0, 32'd5,         32'd0,         32'hFFFFFFFF,  SPEC_LAT, 1, "divu_5_0");    wait_drain();
        issue(0, 1, 32'd5,         32'd0,         32'd5,         SPEC_LAT, 1, "remu_5_0");    wait_drain();
        issue(1, 0, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  SPEC_LAT, 1, "div_m5_0");    wait_drain();
        issue(1, 1, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFB,  SPEC_LAT, 1, "rem_m5_0");    wait_drain();
        issue(1, 0, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  SPEC_LAT, 1, "div_ovf");     wait_drain();
        issue(1, 1, 32'h80000000,  32'hFFFFFFFF,  32'd0,         SPEC_LAT, 1, "rem_ovf");     wait_drain();

        // Consumer stalls for 10 cycles: result held, in_ready stays low
        out_ready = 1'b0;
        issue(0, 0, 32'd1000, 32'd10, 32'd100, FULL_LAT, 1, "hold_divu");
        begin : wait_valid
            int t = 0;
            while (!out_valid && t < 200) begin
                @(posedge clk); #1;
                t++;
            end
            if (t >= 200) chk("hold_wait_valid", 32'd0, 32'd1);
        end
        cycles(10);
        chk("hold_still_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        wait_drain();

        // Flush at BUSY cycle 12: back to IDLE, no result; then a clean op
        issue(0, 0, 32'd50, 32'd5, 32'd10, FULL_LAT, 0, "flushed_op");
        cycles(11);
        flush = 1'b1;
        #1;
        chk("flush_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        chk("flush_idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_no_out_valid",  {31'd0, out_valid}, 32'd0);
        cycles(FULL_LAT);
        issue(0, 0, 32'd9, 32'd3, 32'd3, FULL_LAT, 1, "divu_9_3_after_flush");
        wait_drain();

        // Flush while idle blocks acceptance
        flush = 1'b1; in_valid = 1'b1; in_dividend = 32'd8; in_divisor = 32'd2;
        in_signed = 1'b0; in_rem = 1'b0;
        #1;
        chk("idle_flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        cycles(FULL_LAT + 2);

        // Reset mid-operation: outputs clear at once, ready after release
        issue(0, 0, 32'd77, 32'd7, 32'd11, FULL_LAT, 0, "reset_op");
        cycles(4);
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid",  {31'd0, out_valid}, 32'd0);
        chk("midreset_out_result", out_result, 32'd0);
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        cycles(FULL_LAT + 2);

        // Normal operation resumes after reset
        issue(1, 0, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, FULL_LAT, 1, "div_m100_7");
        wait_drain();
        cycles(2);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
